// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the sequential SubBytes block.
//   byte_t   : one AES state byte
//   state_t  : 128-bit AES state, byte 0 in the MSBs (column-major order)
//   NBYTES   : bytes per AES state
//   fsm_e    : operation sequencer states (IDLE, RUN, FLUSH, DONE)
//   get_byte : extract byte i of a state using the byte ordering above
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NBYTES = 16;

  typedef logic [7:0]          byte_t;
  typedef logic [8*NBYTES-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  // Byte 0 lives in bits [127:120], byte 15 in bits [7:0].
  function automatic byte_t get_byte(input state_t s, input int i);
    return s[8*(NBYTES-1-i) +: 8];
  endfunction

endpackage

// File: rtl/sub_bytes_seq_if.sv
// ---------------------------------------------------------------------------
// sub_bytes_seq_if
// Request/result bundle between a requester and sub_bytes_seq.
//   start     : request to substitute the state presented on in
//   in        : 128-bit AES input state
//   out       : 128-bit SubBytes result (same byte order as in)
//   busy      : an operation is in progress
//   done      : one-cycle pulse marking out valid
//   dbg_state : current sequencer state, for observation only
//
// Handshake: start is sampled on a rising clk edge only while busy=0; a start
// seen while busy=1 is dropped (there is no ready/backpressure). in is
// captured on that same edge and may change afterwards. done is a single
// cycle valid for out; there is no acknowledge, the consumer must take out
// during the done cycle.
// ---------------------------------------------------------------------------
interface sub_bytes_seq_if;
  import aes_pkg::*;

  logic   start;
  state_t in;
  state_t out;
  logic   busy;
  logic   done;
  fsm_e   dbg_state;

  modport master (
    output start, in,
    input  out, busy, done, dbg_state
  );

  modport slave (
    input  start, in,
    output out, busy, done, dbg_state
  );

endinterface

// File: rtl/sbox_sync.sv
// ---------------------------------------------------------------------------
// sbox_sync
// FIPS-197 forward S-box as a 256x8 ROM with a registered read.
//   clk    : clock
//   i_addr : byte to substitute
//   o_data : S-box(i_addr), valid one cycle after i_addr is presented
// The read register has no reset: its contents are only consumed when the
// caller's own valid tracking says so.
// ---------------------------------------------------------------------------
module sbox_sync
  import aes_pkg::*;
(
  input  logic  clk,
  input  byte_t i_addr,
  output byte_t o_data
);

  localparam byte_t ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  byte_t r_data;

  always_ff @(posedge clk) begin
    r_data <= ROM[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// sub_bytes_seq
// Sequential AES SubBytes: substitutes LANES bytes per cycle through LANES
// synchronous S-box ROMs, producing the ShiftRows input state.
//   clk    : clock, all state changes on the rising edge
//   nreset : asynchronous active-low reset
//   bus    : sub_bytes_seq_if.slave (start, in, out, busy, done, dbg_state)
// Parameter LANES (1, 2, 4, 8 or 16) sets bytes per cycle.
//
// Timeline for a start sampled at edge T (N = 16/LANES groups):
//   RUN   : edges T+1..T+N load group cnt into the S-box address register
//   ROM   : each group's data appears one cycle after its address
//   out   : each group is written the cycle after its data appears
//   FLUSH : drains the pipeline; the final group is written at T+N+2,
//           which is also the edge that enters DONE
//   DONE  : one cycle, done=1; a start here begins the next operation
// ---------------------------------------------------------------------------
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            nreset,
  sub_bytes_seq_if.slave  bus
);

  localparam int          NGRP     = NBYTES / LANES;
  localparam logic [3:0]  LAST_GRP = 4'(NGRP - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $fatal(1, "sub_bytes_seq: LANES=%0d is not one of 1, 2, 4, 8, 16", LANES);
  end

  fsm_e       r_state;
  state_t     r_hold;
  logic [3:0] r_cnt;
  state_t     r_out;
  logic       r_busy;
  logic       r_done;

  // Address stage: which group the S-box inputs currently hold.
  byte_t      r_addr [LANES];
  logic       r_addr_vld;
  logic [3:0] r_addr_grp;
  logic       r_addr_last;

  // Data stage: which group the S-box outputs currently hold.
  logic       r_data_vld;
  logic [3:0] r_data_grp;
  logic       r_data_last;

  byte_t      w_sdata [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_sbox
    sbox_sync u_sbox (
      .clk    (clk),
      .i_addr (r_addr[g]),
      .o_data (w_sdata[g])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr_vld  <= 1'b0;
      r_addr_grp  <= '0;
      r_addr_last <= 1'b0;
      r_data_vld  <= 1'b0;
      r_data_grp  <= '0;
      r_data_last <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        r_addr[j] <= '0;
      end
    end else begin
      // Address stage is loaded only while RUN walks the holding register.
      r_addr_vld <= (r_state == RUN);
      if (r_state == RUN) begin
        r_addr_grp  <= r_cnt;
        r_addr_last <= (r_cnt == LAST_GRP);
        for (int j = 0; j < LANES; j++) begin
          r_addr[j] <= get_byte(r_hold, int'(r_cnt) * LANES + j);
        end
      end

      // The ROM read register is the data stage; its tags follow one cycle on.
      r_data_vld  <= r_addr_vld;
      r_data_grp  <= r_addr_grp;
      r_data_last <= r_addr_last;

      // Scatter the substituted group into its byte positions of out.
      if (r_data_vld) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (b / LANES == int'(r_data_grp)) begin
            r_out[8*(NBYTES-1-b) +: 8] <= w_sdata[b % LANES];
          end
        end
      end

      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_hold  <= bus.in;
            r_cnt   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_GRP) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          // Leave when the last group is being written into out this edge.
          if (r_data_vld && r_data_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_seq
// Drives three sub_bytes_seq instances (LANES = 1, 4, 16) with identical
// requests and checks done timing, done count and results against an S-box
// computed from GF(2^8) inversion plus the FIPS-197 affine map.
// ---------------------------------------------------------------------------
module tb_sub_bytes_seq;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  logic         tb_start;
  logic [127:0] tb_in;

  sub_bytes_seq_if if1 ();
  sub_bytes_seq_if if4 ();
  sub_bytes_seq_if if16 ();

  assign if1.start  = tb_start;
  assign if1.in     = tb_in;
  assign if4.start  = tb_start;
  assign if4.in     = tb_in;
  assign if16.start = tb_start;
  assign if16.in    = tb_in;

  sub_bytes_seq #(.LANES(1))  dut1  (.clk(clk), .nreset(nreset), .bus(if1));
  sub_bytes_seq #(.LANES(4))  dut4  (.clk(clk), .nreset(nreset), .bus(if4));
  sub_bytes_seq #(.LANES(16)) dut16 (.clk(clk), .nreset(nreset), .bus(if16));

  // Index 0: LANES=1, 1: LANES=4, 2: LANES=16.
  logic [2:0]   done_v;
  logic [2:0]   busy_v;
  logic [127:0] out_v [3];
  assign done_v   = {if16.done, if4.done, if1.done};
  assign busy_v   = {if16.busy, if4.busy, if1.busy};
  assign out_v[0] = if1.out;
  assign out_v[1] = if4.out;
  assign out_v[2] = if16.out;

  // Negedge index (1 = first negedge after the capture edge) at which done
  // must be seen: 16/LANES + 3.
  int lane_n  [3] = '{1, 4, 16};
  int lat_exp [3] = '{19, 7, 4};

  int tests  = 0;
  int failed = 0;

  logic [7:0] sbox_ref [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_ref();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] v);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = sbox_ref[v[127-8*i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request; optionally re-pulse start while busy. All three instances
  // must give exactly one done at their own latency with result exp.
  task automatic run_op(input string tag, input logic [127:0] v,
                        input logic [127:0] exp, input bit repulse);
    int           n_done [3];
    int           first  [3];
    logic [127:0] res    [3];
    for (int d = 0; d < 3; d++) begin
      n_done[d] = 0;
      first[d]  = -1;
      res[d]    = '0;
    end
    @(negedge clk);
    tb_in    = v;
    tb_start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          n_done[d]++;
          if (n_done[d] == 1) begin
            first[d] = k;
            res[d]   = out_v[d];
          end
        end
      end
      if (k == 1) check($sformatf("%s busy", tag), 128'(busy_v), 128'(3'b111));
      tb_start = repulse && (k == 2);
      tb_in    = rand128();
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s L%0d done count", tag, lane_n[d]), 128'(n_done[d]), 128'(1));
      check($sformatf("%s L%0d latency", tag, lane_n[d]), 128'(first[d]), 128'(lat_exp[d]));
      check($sformatf("%s L%0d out", tag, lane_n[d]), res[d], exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] v;
    logic [127:0] v2;
    int           pulse_k [$];
    logic [127:0] pulse_o [$];
    int           n_late [3];

    tb_start = 1'b0;
    tb_in    = '0;
    build_ref();

    // Asynchronous reset, observed before any clock edge.
    #2 nreset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset L%0d out", lane_n[d]), out_v[d], 128'h0);
    end
    check("reset busy", 128'(busy_v), 128'(0));
    check("reset done", 128'(done_v), 128'(0));
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    run_op("zero", 128'h0, {16{8'h63}}, 1'b0);
    run_op("fips", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
           128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);

    // Every S-box input, 16 per operation.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = 8'(16 * k + i);
      run_op($sformatf("exh%0d", k), v, model(v), 1'b0);
    end

    for (int r = 0; r < 4; r++) begin
      v = rand128();
      run_op($sformatf("rand%0d", r), v, model(v), 1'b0);
    end

    // start re-pulsed while busy, in scrambled after capture.
    v = rand128();
    run_op("repulse", v, model(v), 1'b1);

    // Back-to-back on LANES=4: start held through the first DONE.
    v  = rand128();
    v2 = rand128();
    @(negedge clk);
    tb_in    = v;
    tb_start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_v[1]) begin
        pulse_k.push_back(k);
        pulse_o.push_back(out_v[1]);
      end
      if (k == 7) tb_in = v2;
      if (k == 8) tb_start = 1'b0;
    end
    check("b2b pulse count", 128'(pulse_k.size()), 128'(2));
    while (pulse_k.size() < 2) begin
      pulse_k.push_back(-1);
      pulse_o.push_back('0);
    end
    check("b2b first latency", 128'(pulse_k[0]), 128'(7));
    check("b2b second latency", 128'(pulse_k[1]), 128'(14));
    check("b2b first out", pulse_o[0], model(v));
    check("b2b second out", pulse_o[1], model(v2));

    // Reset in the middle of RUN: immediate clear, no done afterwards.
    @(negedge clk);
    tb_in    = rand128();
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("midreset L%0d out", lane_n[d]), out_v[d], 128'h0);
    end
    check("midreset busy", 128'(busy_v), 128'(0));
    check("midreset done", 128'(done_v), 128'(0));
    @(negedge clk);
    nreset = 1'b1;
    for (int d = 0; d < 3; d++) n_late[d] = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (done_v[d]) n_late[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("midreset L%0d no done", lane_n[d]), 128'(n_late[d]), 128'(0));
    end
    run_op("ones", {128{1'b1}}, {16{8'h16}}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
